// File: rtl/note_duration_tracker.sv
// Five-voice MIDI note tracker: allocates voices on note-on, measures how long
// each note is held in clk_in cycles, and reports releases and allocation overflow.
module note_duration_tracker #(
    parameter bit         CHANNEL_FILTER_EN = 1'b0,
    parameter logic [3:0] CHANNEL           = 4'd0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             msg_valid_in,
    input  logic [7:0]       msg_status_in,
    input  logic [7:0]       msg_data1_in,
    input  logic [7:0]       msg_data2_in,
    output logic [4:0][7:0]  notes_out,
    output logic [4:0][31:0] durations_out,
    output logic [4:0]       voice_active_out,
    output logic [4:0]       done_out,
    output logic             overflow_out
);

    localparam int          NUM_VOICES = 5;
    localparam logic [31:0] DUR_MAX    = 32'hFFFF_FFFF;
    localparam logic [7:0]  NO_NOTE    = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } voice_state_t;

    voice_state_t state_q [NUM_VOICES];

    // Pitch class in the upper nibble, octave in the lower; repeated subtraction
    // keeps this a small comparator chain instead of a general divider.
    function automatic logic [7:0] encode_note(input logic [6:0] num);
        logic [6:0] rem;
        logic [3:0] oct;
        rem = num;
        oct = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (rem >= 7'd12) begin
                rem = rem - 7'd12;
                oct = oct + 4'd1;
            end
        end
        return {rem[3:0], oct};
    endfunction

    logic       unused_data1_msb;
    logic       accept;
    logic       is_note_on;
    logic       is_note_off;
    logic [7:0] enc_note;
    logic [4:0] free_vec;
    logic [4:0] match_vec;
    logic [2:0] free_idx;
    logic [2:0] match_idx;
    logic       any_free;
    logic       any_match;

    assign unused_data1_msb = msg_data1_in[7];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        accept      = msg_valid_in &&
                      (!CHANNEL_FILTER_EN || (msg_status_in[3:0] == CHANNEL));
        is_note_on  = accept && (msg_status_in[7:4] == 4'h9) && (msg_data2_in != 8'd0);
        is_note_off = accept && ((msg_status_in[7:4] == 4'h8) ||
                                 ((msg_status_in[7:4] == 4'h9) && (msg_data2_in == 8'd0)));
        enc_note    = encode_note(msg_data1_in[6:0]);

        free_vec  = '0;
        match_vec = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            free_vec[i]  = (state_q[i] == IDLE);
            match_vec[i] = (state_q[i] == HELD) && (notes_out[i] == enc_note);
        end
        any_free  = |free_vec;
        any_match = |match_vec;

        // Scan downwards so the lowest set index is the one left standing.
        free_idx  = 3'd0;
        match_idx = 3'd0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (free_vec[i])  free_idx  = 3'(i);
            if (match_vec[i]) match_idx = 3'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; a later assignment
    // to the same element in this block overrides the earlier default increment.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the per-voice arrays are plain registers, so they are reset
            // explicitly; an unreset memory would leave notes_out undefined.
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i]       <= IDLE;
                notes_out[i]     <= NO_NOTE;
                durations_out[i] <= '0;
            end
            voice_active_out <= '0;
            done_out         <= '0;
            overflow_out     <= 1'b0;
        end else begin
            done_out     <= '0;
            overflow_out <= 1'b0;

            // Held voices count every cycle, including the release edge itself.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (state_q[i] == HELD && durations_out[i] != DUR_MAX) begin
                    durations_out[i] <= durations_out[i] + 32'd1;
                end
            end

            if (is_note_on && !any_match) begin
                if (any_free) begin
                    state_q[free_idx]          <= HELD;
                    notes_out[free_idx]        <= enc_note;
                    durations_out[free_idx]    <= '0;
                    voice_active_out[free_idx] <= 1'b1;
                end else begin
                    overflow_out <= 1'b1;
                end
            end else if (is_note_off && any_match) begin
                state_q[match_idx]          <= IDLE;
                voice_active_out[match_idx] <= 1'b0;
                done_out[match_idx]         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_duration_tracker.sv
// Directed bench for note_duration_tracker: hand-computed expectations for
// allocation, duration counting, release, overflow, saturation, reset and filtering.
module tb_note_duration_tracker;

    logic             clk_in;
    logic             rst_in;
    logic             msg_valid_in;
    logic [7:0]       msg_status_in;
    logic [7:0]       msg_data1_in;
    logic [7:0]       msg_data2_in;
    logic [4:0][7:0]  notes_out;
    logic [4:0][31:0] durations_out;
    logic [4:0]       voice_active_out;
    logic [4:0]       done_out;
    logic             overflow_out;

    logic [4:0][7:0]  f_notes;
    logic [4:0][31:0] f_durations;
    logic [4:0]       f_voice_active;
    logic [4:0]       f_done;
    logic             f_overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    note_duration_tracker dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .msg_valid_in     (msg_valid_in),
        .msg_status_in    (msg_status_in),
        .msg_data1_in     (msg_data1_in),
        .msg_data2_in     (msg_data2_in),
        .notes_out        (notes_out),
        .durations_out    (durations_out),
        .voice_active_out (voice_active_out),
        .done_out         (done_out),
        .overflow_out     (overflow_out)
    );

    note_duration_tracker #(
        .CHANNEL_FILTER_EN (1'b1),
        .CHANNEL           (4'd2)
    ) dut_filt (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .msg_valid_in     (msg_valid_in),
        .msg_status_in    (msg_status_in),
        .msg_data1_in     (msg_data1_in),
        .msg_data2_in     (msg_data2_in),
        .notes_out        (f_notes),
        .durations_out    (f_durations),
        .voice_active_out (f_voice_active),
        .done_out         (f_done),
        .overflow_out     (f_overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents the message for exactly one rising edge and
    // returns at the following negedge, where its effect is visible.
    task automatic send(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
        msg_valid_in  = 1'b1;
        msg_status_in = st;
        msg_data1_in  = d1;
        msg_data2_in  = d2;
        @(negedge clk_in);
        msg_valid_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in        = 1'b1;
        msg_valid_in  = 1'b0;
        msg_status_in = 8'h00;
        msg_data1_in  = 8'h00;
        msg_data2_in  = 8'h00;
        idle(2);
        rst_in = 1'b0;

        // Reset state
        check("rst_active",   32'(voice_active_out), 'h0);
        check("rst_done",     32'(done_out),         'h0);
        check("rst_overflow", 32'(overflow_out),     'h0);
        check("rst_note0",    32'(notes_out[0]),     'hFF);
        check("rst_note4",    32'(notes_out[4]),     'hFF);
        check("rst_dur0",     durations_out[0],      'h0);

        // Single note held for 1000 cycles
        send(8'h90, 8'd60, 8'd100);
        check("on60_note0",   32'(notes_out[0]),     'h05);
        check("on60_active",  32'(voice_active_out), 'h01);
        check("on60_dur0",    durations_out[0],      'd0);
        idle(500);
        check("hold_dur500",  durations_out[0],      'd500);
        idle(499);
        send(8'h80, 8'd60, 8'd0);
        check("off60_dur",    durations_out[0],      'd1000);
        check("off60_done",   32'(done_out),         'h01);
        check("off60_active", 32'(voice_active_out), 'h00);
        idle(1);
        check("off60_done_clr", 32'(done_out),       'h00);
        check("off60_dur_hold", durations_out[0],    'd1000);
        check("off60_note_hold", 32'(notes_out[0]),  'h05);

        // Fill all five voices, then overflow on the sixth
        send(8'h90, 8'd60, 8'd90);
        send(8'h90, 8'd61, 8'd90);
        send(8'h90, 8'd62, 8'd90);
        send(8'h90, 8'd63, 8'd90);
        send(8'h90, 8'd64, 8'd90);
        check("fill_active",  32'(voice_active_out), 'h1F);
        check("fill_note0",   32'(notes_out[0]),     'h05);
        check("fill_note1",   32'(notes_out[1]),     'h15);
        check("fill_note4",   32'(notes_out[4]),     'h45);
        check("fill_ovf_pre", 32'(overflow_out),     'h0);
        send(8'h90, 8'd65, 8'd90);
        check("ovf_pulse",    32'(overflow_out),     'h1);
        check("ovf_active",   32'(voice_active_out), 'h1F);
        check("ovf_note4",    32'(notes_out[4]),     'h45);
        check("ovf_dur0",     durations_out[0],      'd5);
        check("ovf_dur4",     durations_out[4],      'd1);
        // Duplicate note-on: no restart, no overflow
        send(8'h90, 8'd62, 8'd50);
        check("dup_ovf",      32'(overflow_out),     'h0);
        check("dup_dur2",     durations_out[2],      'd4);
        // Note-off with no matching voice
        send(8'h80, 8'd70, 8'd0);
        check("nomatch_done", 32'(done_out),         'h00);
        check("nomatch_active", 32'(voice_active_out), 'h1F);

        // Reset mid-note discards everything; later note-off is ignored
        pulse_reset();
        check("mid_rst_active", 32'(voice_active_out), 'h00);
        check("mid_rst_note2",  32'(notes_out[2]),     'hFF);
        check("mid_rst_dur1",   durations_out[1],      'd0);
        check("mid_rst_done",   32'(done_out),         'h00);
        send(8'h80, 8'd60, 8'd0);
        check("post_rst_off_done", 32'(done_out),      'h00);

        // Release via velocity-zero note-on, then reuse the freed voice
        send(8'h90, 8'd60, 8'd70);
        send(8'h90, 8'd64, 8'd70);
        send(8'h90, 8'd67, 8'd70);
        check("chord_note2",  32'(notes_out[2]),     'h75);
        send(8'h90, 8'd64, 8'd0);
        check("v0off_done",   32'(done_out),         'h02);
        check("v0off_active", 32'(voice_active_out), 'h05);
        check("v0off_dur1",   durations_out[1],      'd2);
        send(8'h90, 8'd69, 8'd70);
        check("reuse_active", 32'(voice_active_out), 'h07);
        check("reuse_note1",  32'(notes_out[1]),     'h95);
        check("reuse_dur1",   durations_out[1],      'd0);

        // Saturation at the top of the duration counter
        pulse_reset();
        send(8'h90, 8'd60, 8'd1);
        force dut.durations_out = {128'd0, 32'hFFFF_FFFE};
        #1;
        release dut.durations_out;
        @(negedge clk_in);
        check("sat_reach",    durations_out[0],      32'hFFFF_FFFF);
        idle(3);
        check("sat_stay",     durations_out[0],      32'hFFFF_FFFF);
        send(8'h80, 8'd60, 8'd0);
        check("sat_done",     32'(done_out),         'h01);
        check("sat_final",    durations_out[0],      32'hFFFF_FFFF);

        // Channel filter (second instance accepts channel 2 only)
        pulse_reset();
        send(8'h93, 8'd60, 8'd80);
        check("filt_ch3_active", 32'(f_voice_active), 'h00);
        check("filt_ch3_note0",  32'(f_notes[0]),     'hFF);
        send(8'h92, 8'd60, 8'd80);
        check("filt_ch2_active", 32'(f_voice_active), 'h01);
        check("filt_ch2_note0",  32'(f_notes[0]),     'h05);
        check("filt_ch2_dur0",   f_durations[0],      'd0);

        // Encoding boundaries on the unfiltered instance (voice 0 holds 60 already)
        send(8'h90, 8'd127, 8'd1);
        check("enc_127",      32'(notes_out[1]),     'h7A);
        send(8'h90, 8'd0, 8'd1);
        check("enc_0",        32'(notes_out[2]),     'h00);
        send(8'h90, 8'h8B, 8'd1);
        check("enc_msb_ign",  32'(notes_out[3]),     'hB0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/note_duration_tracker.md
NOTE_DURATION_TRACKER -- requirements
Module: note_duration_tracker

Interface
REQ-001: Parameter CHANNEL_FILTER_EN, default 0, meaning: 1 = accept only messages whose status[3:0] equals CHANNEL; 0 = accept every channel.
REQ-002: Parameter CHANNEL, default 4'd0, meaning: the MIDI channel accepted when CHANNEL_FILTER_EN = 1.
REQ-003: clk_in  input  1  system clock, 100 MHz nominal; single clock domain.
REQ-004: rst_in  input  1  reset, synchronous, active-high.
REQ-005: msg_valid_in  input  1  one-cycle strobe; a complete MIDI message is present on the three msg_* buses.
REQ-006: msg_status_in  input  8  MIDI status byte.
REQ-007: msg_data1_in  input  8  note number, 0-127.
REQ-008: msg_data2_in  input  8  velocity.
REQ-009: notes_out  output  [4:0][7:0]  per-voice note; [7:4] = pitch class 0-11, [3:0] = octave.
REQ-010: durations_out  output  [4:0][31:0]  per-voice held duration in clk_in cycles.
REQ-011: voice_active_out  output  5  bit i is high while voice i holds a sounding note.
REQ-012: done_out  output  5  bit i is a one-cycle pulse when voice i's note is released.
REQ-013: overflow_out  output  1  one-cycle pulse when a note-on is dropped because no voice is free.

Function
REQ-014: The block SHALL accept one message on every cycle in which msg_valid_in is high; no backpressure exists.
REQ-015: Note-on SHALL be msg_status_in[7:4] = 4'h9 with msg_data2_in != 0.
REQ-016: Note-off SHALL be msg_status_in[7:4] = 4'h8, or 4'h9 with msg_data2_in = 0.
REQ-017: All other statuses, and messages filtered out by REQ-001, SHALL be ignored with no output change.
REQ-018: Note encoding SHALL be: pitch class = data1 mod 12, octave = data1 / 12 (integer division, range 0-10); only data1[6:0] is used.
REQ-019: Each of the five voices SHALL be a two-state FSM, IDLE or HELD; voice_active_out[i] = (state = HELD).
REQ-020: On an accepted note-on, the block SHALL allocate the lowest-index IDLE voice i. At the next edge it SHALL set state = HELD, notes_out[i] = encoded note and durations_out[i] = 0.
REQ-021: If a note-on arrives for a note already HELD in any voice, the block SHALL ignore it: no allocation, no restart, no overflow pulse.
REQ-022: If a note-on arrives with all five voices HELD, the block SHALL drop it and pulse overflow_out for exactly one cycle; voices are unchanged.
REQ-023: While a voice is HELD, durations_out[i] SHALL increment by 1 every cycle, saturating at 32'hFFFF_FFFF with no wrap.
REQ-024: On an accepted note-off, the HELD voice whose notes_out equals the encoded note SHALL be released at the next edge. That edge applies the final increment, sets state = IDLE and pulses done_out[i] high for one cycle.
REQ-025: Duration rule: if the note-on is accepted at edge T and the note-off at edge T+N, the final durations_out[i] SHALL equal N.
REQ-026: A note-off matching no HELD voice SHALL be ignored.
REQ-027: After release, notes_out[i] and durations_out[i] SHALL hold their final values until voice i is reallocated.
REQ-028: All outputs SHALL be registered, with exactly one cycle of latency from message to output change.
REQ-029: At most one voice SHALL change state per cycle.

Reset
REQ-030: While rst_in is high at an edge, every voice SHALL go IDLE. Outputs SHALL be: notes_out[i] = 8'hFF (pitch class 15, no note), durations_out[i] = 0, voice_active_out = 0, done_out = 0, overflow_out = 0.
REQ-031: Reset asserted mid-note SHALL discard the note with no done_out pulse. A later note-off for that note SHALL be ignored.

Verification
REQ-032: Note-on 0x90/60/100, then note-off 0x80/60/0 1000 cycles later -> voice 0 notes_out = 8'h05, final durations_out[0] = 1000, done_out[0] single pulse, voice_active_out = 0.
REQ-033: Six note-ons for notes 60-65 on consecutive cycles -> voices 0-4 hold 60-64; the sixth produces an overflow_out pulse; no voice changes.
REQ-034: Hold notes 60, 64 and 67, then release 64 via 0x90/64/0 -> only voice 1 releases. A following note-on for 69 reuses voice 1, and its duration restarts at 0.
REQ-035: Force durations_out[0] to 32'hFFFF_FFFE while HELD -> it reaches 32'hFFFF_FFFF and stays there; a later release reports 32'hFFFF_FFFF.
REQ-036: Assert rst_in for one cycle while voices 0-2 are HELD -> all outputs at reset values the next cycle; a subsequent note-off for 60 produces no done_out pulse.
REQ-037: With CHANNEL_FILTER_EN = 1 and CHANNEL = 2, send note-on 0x93/60/80 -> no output change; send note-on 0x92/60/80 -> voice 0 allocated.
